uart_rx_fifo: RTL and testbench

//   Receive buffer directly downstream of the UART receiver. Captures each byte
//   the receiver presents (recv_valid/recv_data) into a circular FIFO. Lets the

---
 rtl/uart_rx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART receiver and the host.
//   Captures one byte per rising edge of recv_valid into a circular FIFO,
//   lets the host pop bytes with a 1-cycle read latency, and reports
//   level/empty/full plus a sticky overrun flag for bytes dropped while full.
//
// Optional feature macro: UART_RX_FIFO_BREAK_FILTER_EN
//   defined   : BREAK strobes set break_seen and are not stored
//   undefined : BREAK bytes are stored like data, break_seen tied to 0
//
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   recv_valid/data/break   receiver byte interface (level-valid)
//   rd_en                   host pop request
//   clr_overrun             clears the sticky overrun flag
//   rd_data, rd_valid       popped byte and its 1-cycle valid pulse
//   empty, full, level      fill status (registered)
//   overrun, break_seen     sticky status flags
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          recv_valid,
  input  logic [7:0]    recv_data,
  input  logic          recv_break,
  input  logic          rd_en,
  input  logic          clr_overrun,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic          break_seen
);

  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          valid_q, valid_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          overrun_q, overrun_d;
  logic          break_seen_q, break_seen_d;

  logic          wr_stb_c;
  logic          wr_req_c;
  logic          brk_set_c;
  logic          rd_acc_c;
  logic          wr_acc_c;
  logic          ovr_set_c;

  // Strobe and accept qualification
  always_comb begin
    wr_stb_c  = recv_valid & ~valid_q;
`ifdef UART_RX_FIFO_BREAK_FILTER_EN
    // BREAK strobes are diverted to the flag and never compete for a slot
    brk_set_c = wr_stb_c & recv_break;
    wr_req_c  = wr_stb_c & ~recv_break;
`else
    brk_set_c = 1'b0;
    wr_req_c  = wr_stb_c;
`endif
    rd_acc_c  = rd_en & ~empty_q;
    // A concurrent pop frees a slot even when full
    wr_acc_c  = wr_req_c & (~full_q | rd_acc_c);
    ovr_set_c = wr_req_c & full_q & ~rd_acc_c;
  end

`ifndef UART_RX_FIFO_BREAK_FILTER_EN
  logic unused_recv_break;
  assign unused_recv_break = recv_break;
`endif

  // Next-state logic
  always_comb begin
    valid_d      = recv_valid;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_acc_c;

    if (wr_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc_c) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem[rd_ptr_q];
    end

    level_d      = level_q + LW'(wr_acc_c) - LW'(rd_acc_c);
    empty_d      = (level_d == '0);
    full_d       = (level_d == LW'(DEPTH));

    // Set wins over a coincident clear
    overrun_d    = ovr_set_c | (overrun_q & ~clr_overrun);

`ifdef UART_RX_FIFO_BREAK_FILTER_EN
    break_seen_d = brk_set_c | (break_seen_q & ~(rd_en & empty_q));
`else
    break_seen_d = 1'b0;
`endif
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      valid_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= 8'h00;
      overrun_q    <= 1'b0;
      break_seen_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      valid_q      <= valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      overrun_q    <= overrun_d;
      break_seen_q <= break_seen_d;
    end
  end

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (resetn && wr_acc_c) mem[wr_ptr_q] <= recv_data;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign level      = level_q;
  assign overrun    = overrun_q;
  assign break_seen = break_seen_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
`ifdef UART_RX_FIFO_BREAK_FILTER_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          recv_valid;
  logic [7:0]    recv_data;
  logic          recv_break;
  logic          rd_en;
  logic          clr_overrun;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overrun;
  logic          break_seen;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_prev_v;
  logic       m_ovr;
  logic       m_brk;
  logic       m_rv;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .recv_valid  (recv_valid),
    .recv_data   (recv_data),
    .recv_break  (recv_break),
    .rd_en       (rd_en),
    .clr_overrun (clr_overrun),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .overrun     (overrun),
    .break_seen  (break_seen)
  );

  task automatic model_reset();
    mq.delete();
    m_prev_v = 1'b0;
    m_ovr    = 1'b0;
    m_brk    = 1'b0;
    m_rv     = 1'b0;
    m_rdata  = 8'h00;
  endtask

  // Apply one cycle of inputs, advance past the clock edge, update the model
  task automatic cycle(input logic v, input logic [7:0] d, input logic b,
                       input logic rd, input logic clr);
    logic stb, racc, set_o, set_b;
    int   sz;
    recv_valid  = v;
    recv_data   = d;
    recv_break  = b;
    rd_en       = rd;
    clr_overrun = clr;
    @(posedge clk);
    #1;
    if (!resetn) begin
      model_reset();
      return;
    end
    sz       = mq.size();
    stb      = v && !m_prev_v;
    racc     = rd && (sz != 0);
    m_prev_v = v;
    m_rv     = racc;
    if (racc) m_rdata = mq.pop_front();
    set_o = 1'b0;
    set_b = 1'b0;
    if (stb) begin
      if (BRK_EN && b) set_b = 1'b1;
      else if (sz < int'(DEPTH) || racc) mq.push_back(d);
      else set_o = 1'b1;
    end
    m_ovr = set_o || (m_ovr && !clr);
    m_brk = set_b || (BRK_EN && m_brk && !(rd && sz == 0));
  endtask

  task automatic strobe(input logic [7:0] d, input logic b);
    cycle(1'b1, d, b, 1'b0, 1'b0);
    cycle(1'b0, d, b, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    strobe(8'h11, 1'b0);
    strobe(8'h22, 1'b0);
    do_reset();
    n_total++;
    if ({empty, full, level, rd_valid, overrun, break_seen, rd_data} !==
        {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_state: got e=%b f=%b lvl=%0d rv=%b ovr=%b brk=%b rd=%h want e=1 f=0 lvl=0 rv=0 ovr=0 brk=0 rd=00",
               empty, full, level, rd_valid, overrun, break_seen, rd_data);
    else n_pass++;
  endtask

  task automatic test_held_valid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    n_total++;
    if (level !== 5'd1) $display("FAIL held_level: got %0d want 1", level);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({rd_valid, rd_data, empty} !== {1'b1, 8'hA5, 1'b1})
      $display("FAIL held_read: got rv=%b rd=%h e=%b want rv=1 rd=a5 e=1", rd_valid, rd_data, empty);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({rd_valid, rd_data} !== {1'b0, 8'hA5})
      $display("FAIL held_pulse: got rv=%b rd=%h want rv=0 rd=a5", rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) strobe(8'(i), 1'b0);
    n_total++;
    if ({full, empty, level} !== {1'b1, 1'b0, 5'd16})
      $display("FAIL fill_full: got f=%b e=%b lvl=%0d want f=1 e=0 lvl=16", full, empty, level);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_total++;
      if ({rd_valid, rd_data} !== {1'b1, 8'(i)})
        $display("FAIL drain_%0d: got rv=%b rd=%h want rv=1 rd=%h", i, rd_valid, rd_data, 8'(i));
      else n_pass++;
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({rd_valid, empty, level} !== {1'b0, 1'b1, 5'd0})
      $display("FAIL read_empty: got rv=%b e=%b lvl=%0d want rv=0 e=1 lvl=0", rd_valid, empty, level);
    else n_pass++;
    strobe(8'h10, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h10})
      $display("FAIL wrap_read: got rv=%b rd=%h want rv=1 rd=10", rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 16; i++) strobe(8'h20 + 8'(i), 1'b0);
    strobe(8'hEE, 1'b0);
    n_total++;
    if ({overrun, level, full} !== {1'b1, 5'd16, 1'b1})
      $display("FAIL overrun_set: got ovr=%b lvl=%0d f=%b want ovr=1 lvl=16 f=1", overrun, level, full);
    else n_pass++;
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (overrun !== 1'b1) $display("FAIL overrun_set_wins: got %b want 1", overrun);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", overrun);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_total++;
      if ({rd_valid, rd_data} !== {1'b1, 8'h20 + 8'(i)})
        $display("FAIL overrun_drain_%0d: got rv=%b rd=%h want rv=1 rd=%h", i, rd_valid, rd_data, 8'h20 + 8'(i));
      else n_pass++;
    end
    n_total++;
    if (empty !== 1'b1) $display("FAIL overrun_empty: got %b want 1", empty);
    else n_pass++;
  endtask

  task automatic test_coincident();
    do_reset();
    for (int i = 0; i < 16; i++) strobe(8'h40 + 8'(i), 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({level, full, overrun, rd_valid, rd_data} !== {5'd16, 1'b1, 1'b0, 1'b1, 8'h40})
      $display("FAIL full_both: got lvl=%0d f=%b ovr=%b rv=%b rd=%h want lvl=16 f=1 ovr=0 rv=1 rd=40",
               level, full, overrun, rd_valid, rd_data);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h4F})
      $display("FAIL full_both_order: got rv=%b rd=%h want rv=1 rd=4f", rd_valid, rd_data);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({rd_valid, rd_data, empty} !== {1'b1, 8'h55, 1'b1})
      $display("FAIL full_both_last: got rv=%b rd=%h e=%b want rv=1 rd=55 e=1", rd_valid, rd_data, empty);
    else n_pass++;

    do_reset();
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({rd_valid, level, rd_data} !== {1'b0, 5'd1, 8'h00})
      $display("FAIL empty_both: got rv=%b lvl=%0d rd=%h want rv=0 lvl=1 rd=00", rd_valid, level, rd_data);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h77})
      $display("FAIL empty_both_read: got rv=%b rd=%h want rv=1 rd=77", rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_break();
    do_reset();
    strobe(8'h00, 1'b1);
    if (BRK_EN) begin
      n_total++;
      if ({break_seen, level, empty} !== {1'b1, 5'd0, 1'b1})
        $display("FAIL break_filter: got brk=%b lvl=%0d e=%b want brk=1 lvl=0 e=1", break_seen, level, empty);
      else n_pass++;
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_total++;
      if ({break_seen, rd_valid} !== {1'b0, 1'b0})
        $display("FAIL break_clear: got brk=%b rv=%b want brk=0 rv=0", break_seen, rd_valid);
      else n_pass++;
    end else begin
      n_total++;
      if ({break_seen, level} !== {1'b0, 5'd1})
        $display("FAIL break_store: got brk=%b lvl=%0d want brk=0 lvl=1", break_seen, level);
      else n_pass++;
      cycle(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
      n_total++;
      if ({rd_valid, rd_data, break_seen} !== {1'b1, 8'h00, 1'b0})
        $display("FAIL break_read: got rv=%b rd=%h brk=%b want rv=1 rd=00 brk=0", rd_valid, rd_data, break_seen);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic rd;
    int   errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      // Alternate slow-drain and fast-drain phases to reach full and empty
      if (((c / 400) % 2) == 0) rd = ($urandom_range(0, 15) == 0);
      else rd = ($urandom_range(0, 1) == 0);
      cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 7) == 0,
            rd, $urandom_range(0, 31) == 0);
      n_total++;
      if ({level, empty, full, overrun, break_seen, rd_valid} !==
          {5'(mq.size()), mq.size() == 0, mq.size() == int'(DEPTH), m_ovr, m_brk, m_rv}) begin
        if (errs < 10)
          $display("FAIL rand_flags_c%0d: got lvl=%0d e=%b f=%b ovr=%b brk=%b rv=%b want lvl=%0d e=%b f=%b ovr=%b brk=%b rv=%b",
                   c, level, empty, full, overrun, break_seen, rd_valid,
                   mq.size(), mq.size() == 0, mq.size() == int'(DEPTH), m_ovr, m_brk, m_rv);
        errs++;
      end else n_pass++;
      n_total++;
      if (rd_data !== m_rdata) begin
        if (errs < 10) $display("FAIL rand_data_c%0d: got %h want %h", c, rd_data, m_rdata);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    resetn      = 1'b0;
    recv_valid  = 1'b0;
    recv_data   = 8'h00;
    recv_break  = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
    model_reset();
    do_reset();
    test_reset();
    test_held_valid();
    test_fill_wrap();
    test_overrun();
    test_coincident();
    test_break();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
